// File: rtl/cache_1_ctrl.sv
// cache_1_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// Eight one-word lines. Sequences a synchronous-read tag RAM and data RAM and
// hands misses and all writes to the backing memory. After reset it clears
// every tag before it accepts the first CPU request.
module cache_1_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int IDX_WIDTH  = 3,
    parameter int TAG_WIDTH  = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [IDX_WIDTH-1:0]  tag_addr,
    output logic                  tag_we,
    output logic [TAG_WIDTH-1:0]  tag_wdata,
    input  logic [TAG_WIDTH-1:0]  tag_rdata,
    output logic [IDX_WIDTH-1:0]  data_addr,
    output logic                  data_we,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int ATAG_WIDTH = ADDR_WIDTH - IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        MEM_RD,
        FILL,
        MEM_WR
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDX_WIDTH-1:0]  init_idx;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [IDX_WIDTH-1:0]  lat_idx;
    logic [ATAG_WIDTH-1:0] lat_tag;
    logic                  hit;

    assign lat_idx   = lat_addr[IDX_WIDTH-1:0];
    assign lat_tag   = lat_addr[ADDR_WIDTH-1:IDX_WIDTH];
    assign hit       = tag_rdata[TAG_WIDTH-1] && (tag_rdata[ATAG_WIDTH-1:0] == lat_tag);
    assign data_addr = tag_addr;

    // State register; reset always restarts the tag-clearing sequence.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection from the current state, request and memory handshake.
    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (init_idx == LAST_IDX) next_state = IDLE;
            IDLE:    if (cpu_valid) next_state = LOOKUP;
            LOOKUP: begin
                if (lat_we)   next_state = MEM_WR;
                else if (hit) next_state = IDLE;
                else          next_state = MEM_RD;
            end
            MEM_RD:  if (mem_ack) next_state = FILL;
            FILL:    next_state = IDLE;
            MEM_WR:  if (mem_ack) next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // RAM and memory port drive; tag writes are held off while reset is asserted.
    always_comb begin
        cpu_ready  = 1'b0;
        tag_addr   = lat_idx;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = 1'b0;
        data_wdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            INIT: begin
                tag_addr = init_idx;
                tag_we   = reset_n;
            end
            IDLE: begin
                cpu_ready = 1'b1;
                tag_addr  = cpu_addr[IDX_WIDTH-1:0];
            end
            LOOKUP: begin
                if (lat_we && hit) begin
                    data_we    = 1'b1;
                    data_wdata = lat_wdata;
                end
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = lat_addr;
            end
            FILL: begin
                tag_we     = 1'b1;
                tag_wdata  = {1'b1, lat_tag};
                data_we    = 1'b1;
                data_wdata = cpu_rdata;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            default: ;
        endcase
    end

    // Request capture, read data, completion pulse and saturating statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_idx       <= '0;
            lat_addr       <= '0;
            lat_we         <= 1'b0;
            lat_wdata      <= '0;
            cpu_rdata      <= '0;
            cpu_resp_valid <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            if (state == INIT) begin
                init_idx <= init_idx + IDX_WIDTH'(1);
            end
            if (state == IDLE && cpu_valid) begin
                lat_addr  <= cpu_addr;
                lat_we    <= cpu_we;
                lat_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                if (hit) begin
                    if (hit_count != '1) hit_count <= hit_count + 16'd1;
                    if (!lat_we) begin
                        cpu_rdata      <= data_rdata;
                        cpu_resp_valid <= 1'b1;
                    end
                end else if (miss_count != '1) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
            if (state == MEM_RD && mem_ack) begin
                cpu_rdata <= mem_rdata;
            end
            if (state == FILL || (state == MEM_WR && mem_ack)) begin
                cpu_resp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_1_ctrl.sv
// tb_cache_1_ctrl: directed and randomized bench for cache_1_ctrl with tag/data
// RAM models, a backing memory with programmable ack latency and a behavioural
// cache model that predicts every response.
module tb_cache_1_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_resp_valid;
    logic [7:0]  cpu_rdata;
    logic [2:0]  tag_addr;
    logic        tag_we;
    logic [13:0] tag_wdata;
    logic [13:0] tag_rdata;
    logic [2:0]  data_addr;
    logic        data_we;
    logic [7:0]  data_wdata;
    logic [7:0]  data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    cache_1_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_valid      (cpu_valid),
        .cpu_ready      (cpu_ready),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .tag_addr       (tag_addr),
        .tag_we         (tag_we),
        .tag_wdata      (tag_wdata),
        .tag_rdata      (tag_rdata),
        .data_addr      (data_addr),
        .data_we        (data_we),
        .data_wdata     (data_wdata),
        .data_rdata     (data_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clock = ~clock;

    // Backing memory power-up contents: 0x0015 holds 0xA5.
    function automatic logic [7:0] initByte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB0;
    endfunction

    logic        preload;
    logic [13:0] tag_mem [8];
    logic [7:0]  dat_mem [8];
    logic [13:0] tag_q;
    logic [7:0]  dat_q;

    // Synchronous-read tag and data RAMs with a registered read address.
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) begin
                tag_mem[i] <= 14'h3FFF;
                dat_mem[i] <= 8'hEE;
            end
        end else begin
            if (tag_we)  tag_mem[tag_addr]  <= tag_wdata;
            if (data_we) dat_mem[data_addr] <= data_wdata;
        end
        tag_q <= tag_mem[tag_addr];
        dat_q <= dat_mem[data_addr];
    end

    assign tag_rdata  = tag_q;
    assign data_rdata = dat_q;

    logic [7:0] bmem [65536];
    int         mem_lat;
    int         wait_cnt;

    // Backing memory: acks after mem_lat extra cycles, performs the access on ack.
    always @(negedge clock) begin
        if (preload) begin
            for (int i = 0; i < 65536; i++) bmem[i] <= initByte(i[15:0]);
            mem_ack  <= 1'b0;
            wait_cnt <= 0;
        end else if (!mem_req || mem_ack) begin
            mem_ack  <= 1'b0;
            wait_cnt <= mem_lat;
        end else if (wait_cnt == 0) begin
            mem_ack <= 1'b1;
            if (mem_we) bmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bmem[mem_addr];
        end else begin
            wait_cnt <= wait_cnt - 1;
        end
    end

    // Behavioural cache model state.
    bit          m_valid [8];
    logic [12:0] m_tag   [8];
    logic [7:0]  m_data  [8];
    logic [7:0]  ref_mem [65536];
    int          exp_hits;
    int          exp_misses;
    logic [7:0]  last_rdata;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        last_rdata = 8'h00;
    endtask

    // Expects reset_n low on entry; checks reset outputs, releases reset, follows INIT.
    task automatic resetAndInit();
        #1;
        checkOutput("rst_cpu_ready", cpu_ready, 0);
        checkOutput("rst_tag_we", tag_we, 0);
        checkOutput("rst_data_we", data_we, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_resp_valid", cpu_resp_valid, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_hit_count", hit_count, 0);
        checkOutput("rst_miss_count", miss_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("init_tag_we", tag_we, 1);
            checkOutput("init_tag_addr", tag_addr, i);
            checkOutput("init_tag_wdata", tag_wdata, 0);
            checkOutput("init_cpu_ready", cpu_ready, 0);
            @(negedge clock);
        end
        checkOutput("init_done_ready", cpu_ready, 1);
        for (int i = 0; i < 8; i++) checkOutput("init_tag_cleared", tag_mem[i], 0);
    endtask

    task automatic acceptRequest(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        int n = 0;
        while (!cpu_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("ready_wait", (n < 100), 1);
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clock);
        #1;
        cpu_valid = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = 16'($urandom);
        cpu_wdata = 8'($urandom);
    endtask

    // One full CPU transaction, predicted by the model and checked on completion.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        logic [2:0]  idx;
        logic [12:0] tg;
        logic [7:0]  exp_data;
        bit          exp_hit;
        bit          got;
        bit          saw_req;
        bit          saw_dwe;
        bit          saw_twe;
        int          lat;
        idx     = addr[2:0];
        tg      = addr[15:3];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (exp_hit) begin
            if (exp_hits < 65535) exp_hits++;
        end else if (exp_misses < 65535) begin
            exp_misses++;
        end
        if (!we) begin
            exp_data = exp_hit ? m_data[idx] : ref_mem[addr];
            if (!exp_hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = exp_data;
            end
            last_rdata = exp_data;
        end else begin
            ref_mem[addr] = wdata;
            if (exp_hit) m_data[idx] = wdata;
            exp_data = last_rdata;
        end

        acceptRequest(we, addr, wdata);
        got     = 1'b0;
        saw_req = 1'b0;
        saw_dwe = 1'b0;
        saw_twe = 1'b0;
        lat     = 0;
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            if (mem_req) saw_req = 1'b1;
            if (data_we) saw_dwe = 1'b1;
            if (tag_we)  saw_twe = 1'b1;
            if (cpu_resp_valid) got = 1'b1;
        end
        checkOutput("resp_seen", got, 1);
        checkOutput("cpu_rdata", cpu_rdata, exp_data);
        checkOutput("hit_count", hit_count, exp_hits);
        checkOutput("miss_count", miss_count, exp_misses);
        if (!we && exp_hit) begin
            checkOutput("hit_latency", lat, 2);
            checkOutput("hit_no_mem_req", saw_req, 0);
        end else begin
            checkOutput("mem_req_used", saw_req, 1);
            checkOutput("slow_latency", (lat > 2), 1);
        end
        if (we) begin
            checkOutput("wr_data_we", saw_dwe, exp_hit);
            checkOutput("wr_tag_untouched", saw_twe, 0);
            checkOutput("wr_mem_contents", bmem[addr], wdata);
            if (exp_hit) checkOutput("wr_hit_ram_data", dat_mem[idx], wdata);
        end else if (!exp_hit) begin
            checkOutput("fill_tag", tag_mem[idx], {1'b1, tg});
            checkOutput("fill_data", dat_mem[idx], exp_data);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

    // Directed test plan, randomized traffic, reset mid-read, counter saturation.
    initial begin
        int n;
        int tsel;
        logic [12:0] tagv;
        reset_n   = 1'b0;
        preload   = 1'b1;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        mem_lat   = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = initByte(i[15:0]);
        modelReset();
        repeat (2) @(posedge clock);
        preload = 1'b0;
        resetAndInit();

        mem_lat = 2;
        applyStimulus(1'b0, 16'h0015, 8'h00);
        applyStimulus(1'b0, 16'h0015, 8'h00);
        applyStimulus(1'b1, 16'h0015, 8'h3C);
        applyStimulus(1'b0, 16'h0015, 8'h00);
        applyStimulus(1'b1, 16'h0815, 8'h77);
        applyStimulus(1'b0, 16'h0015, 8'h00);

        for (int k = 0; k < 60; k++) begin
            mem_lat = $urandom_range(0, 3);
            tsel    = $urandom_range(0, 2);
            tagv    = (tsel == 0) ? 13'h002 : ((tsel == 1) ? 13'h102 : 13'h003);
            applyStimulus(1'($urandom_range(0, 1)), {tagv, 3'($urandom_range(0, 7))}, 8'($urandom));
        end

        mem_lat = 20;
        acceptRequest(1'b0, 16'hFFFD, 8'h00);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput("mem_rd_active", mem_req, 1);
        #2;
        reset_n = 1'b0;
        modelReset();
        resetAndInit();

        mem_lat = 1;
        applyStimulus(1'b0, 16'h0015, 8'h00);
        force dut.hit_count = 16'hFFFC;
        #1;
        release dut.hit_count;
        exp_hits = 16'hFFFC;
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 16'h0015, 8'h00);
        checkOutput("hit_saturated", hit_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
